data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem.sv | 178 +++++++++++++++++
 tb/tb_data_mem.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// Word-organised data memory with RISC-V byte/half/word access, fixed response
// latency, fault detection and a saturating fault counter.
module data_mem #(
   parameter int unsigned N       = 12,
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [2:0]  req_width,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [15:0] err_count
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        go_q, go_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [15:0] errcnt_q, errcnt_d;

   logic [31:0] addr_q;
   logic        we_q;
   logic [2:0]  width_q;
   logic [31:0] wdata_q;

   logic [31:0] mem [0:(1 << N) - 1];

   logic [N-1:0] idx;
   logic [1:0]   lane;
   logic         out_of_range, misaligned, bad_width, fault;
   logic [31:0]  word, shifted, load_fmt, load_data;
   logic [7:0]   byte_sel;
   logic [15:0]  half_sel;
   logic [3:0]   be;
   logic [31:0]  wlanes;
   logic         access, mem_we;

   assign idx          = addr_q[N+1:2];
   assign lane         = addr_q[1:0];
   assign out_of_range = (addr_q >> (N + 2)) != '0;
   assign access       = (state_q == S_WAIT) && go_q;
   assign mem_we       = access && !fault && we_q && !rst;

   always_comb begin
      misaligned = 1'b0;
      bad_width  = 1'b0;
      unique case (width_q)
         3'b000:  ;
         3'b001:  misaligned = addr_q[0];
         3'b010:  misaligned = |lane;
         3'b100:  bad_width  = we_q;
         3'b101:  begin bad_width = we_q; misaligned = addr_q[0]; end
         default: bad_width  = 1'b1;
      endcase
      fault = out_of_range | misaligned | bad_width;
   end

   // Read is combinational off the latched address; the response register captures it.
   always_comb begin
      word     = mem[idx];
      shifted  = word >> {lane, 3'b000};
      byte_sel = shifted[7:0];
      half_sel = lane[1] ? word[31:16] : word[15:0];
      unique case (width_q)
         3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
         3'b010:  load_fmt = word;
         3'b100:  load_fmt = {24'h0, byte_sel};
         3'b101:  load_fmt = {16'h0, half_sel};
         default: load_fmt = '0;
      endcase
      load_data = (we_q || fault) ? '0 : load_fmt;
   end

   always_comb begin
      unique case (width_q[1:0])
         2'b00:   begin be = 4'b0001 << lane; wlanes = {4{wdata_q[7:0]}}; end
         2'b01:   begin be = lane[1] ? 4'b1100 : 4'b0011; wlanes = {2{wdata_q[15:0]}}; end
         default: begin be = 4'b1111; wlanes = wdata_q; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if ((state_q == S_IDLE) && req_valid) begin
         addr_q  <= req_addr;
         we_q    <= req_we;
         width_q <= req_width;
         wdata_q <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         go_q     <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         errcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         go_q     <= go_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         errcnt_q <= errcnt_d;
      end
   end

   // go_q marks the counter having reached zero; the access happens one edge later.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      go_d     = go_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      errcnt_d = errcnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_WAIT;
               cnt_d   = CNT_INIT;
               go_d    = 1'b0;
            end
         end
         S_WAIT: begin
            if (go_q) begin
               state_d = S_RESP;
               rdata_d = load_data;
               err_d   = fault;
               go_d    = 1'b0;
            end else if (cnt_q == '0) begin
               go_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
               if (err_q && (errcnt_q != '1)) errcnt_d = errcnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == S_IDLE);
      resp_valid = (state_q == S_RESP);
      resp_rdata = rdata_q;
      resp_err   = err_q;
      err_count  = errcnt_q;
   end

endmodule

// File: tb/tb_data_mem.sv
// Directed and randomised checks of data_mem (N=12, LATENCY=3) against a
// byte-addressed reference memory.
module tb_data_mem;

   localparam int unsigned LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        req_we = 1'b0;
   logic [2:0]  req_width = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [15:0] err_count;

   int unsigned ncmp = 0;
   int unsigned nfail = 0;
   int unsigned err_m = 0;
   logic [7:0]  mem_m [0:16383];

   data_mem #(.N(12), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .req_width(req_width), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: little-endian byte array, 16 KiB, RISC-V load/store rules.
   function automatic void model(input logic we, input logic [2:0] w, input logic [31:0] a,
                                 input logic [31:0] d, output logic [31:0] rd, output logic er);
      int unsigned size;
      logic [31:0] val, tmp;
      case (w)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      er = (size == 0) || (we && w[2]) || (a >= 32'h4000) || ((size != 0) && (a % size != 0));
      rd = '0;
      if (!er) begin
         if (we) begin
            for (int i = 0; i < int'(size); i++) begin
               tmp = d >> (8 * i);
               mem_m[a + i] = tmp[7:0];
            end
         end else begin
            val = '0;
            for (int i = 0; i < int'(size); i++) val = val | (32'(mem_m[a + i]) << (8 * i));
            if (!w[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
            rd = val;
         end
      end
   endfunction

   task automatic xact(input logic we, input logic [2:0] w, input logic [31:0] a,
                       input logic [31:0] d, input int stall);
      logic [31:0] exp_d;
      logic        exp_e;
      int          n;
      model(we, w, a, d, exp_d, exp_e);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_width = w; req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", 32'(n), 32'(LAT + 1));
      chk("rdata", resp_rdata, exp_d);
      chk("err", 32'(resp_err), 32'(exp_e));
      for (int s = 0; s < stall; s++) begin
         // A competing store is presented during the stall and must be ignored.
         req_valid = 1'b1; req_we = 1'b1; req_width = 3'd2;
         req_addr = 32'h30; req_wdata = 32'hA5A5_A5A5;
         @(posedge clk); #1;
         chk("stall_valid", 32'(resp_valid), 32'd1);
         chk("stall_ready", 32'(req_ready), 32'd0);
         chk("stall_rdata", resp_rdata, exp_d);
         chk("stall_err", 32'(resp_err), 32'(exp_e));
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      if (exp_e && err_m < 16'hFFFF) err_m++;
      chk("post_hs_valid", 32'(resp_valid), 32'd0);
      chk("post_hs_ready", 32'(req_ready), 32'd1);
      chk("err_count", 32'(err_count), err_m);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_err"}, 32'(resp_err), 32'd0);
      chk({tag, "_errcnt"}, 32'(err_count), 32'd0);
   endtask

   initial begin
      logic [2:0] codes [0:7];
      logic [2:0] w;
      logic [31:0] a;
      int n;
      codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_reset_state("reset");

      for (int i = 0; i < 64; i++) xact(1'b1, 3'd2, 32'(4 * i), $urandom, 0);

      xact(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0);
      xact(1'b0, 3'd2, 32'h10, 32'h0, 0);
      chk("lw_dead", resp_rdata, 32'h0);
      xact(1'b0, 3'd0, 32'h13, 32'h0, 0);
      xact(1'b0, 3'd4, 32'h13, 32'h0, 0);
      xact(1'b0, 3'd1, 32'h10, 32'h0, 0);
      xact(1'b0, 3'd5, 32'h12, 32'h0, 0);
      xact(1'b1, 3'd0, 32'h11, 32'h55, 0);
      xact(1'b0, 3'd2, 32'h10, 32'h0, 0);

      xact(1'b0, 3'd2, 32'h12, 32'h0, 0);
      xact(1'b1, 3'd1, 32'h11, 32'hFFFF, 0);
      xact(1'b0, 3'd3, 32'h10, 32'h0, 0);
      xact(1'b0, 3'd2, 32'h4000, 32'h0, 0);
      chk("err_count_4", 32'(err_count), 32'd4);
      xact(1'b0, 3'd2, 32'h10, 32'h0, 0);

      xact(1'b0, 3'd2, 32'h18, 32'h0, 10);
      xact(1'b0, 3'd2, 32'h30, 32'h0, 0);

      // Reset while the store is still waiting: the store must not land.
      req_valid = 1'b1; req_we = 1'b1; req_width = 3'd2;
      req_addr = 32'h20; req_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      err_m = 0;
      chk_reset_state("rst_wait");
      xact(1'b0, 3'd2, 32'h20, 32'h0, 0);

      // Reset during a pending response, with a handshake on the same edge.
      req_valid = 1'b1; req_we = 1'b0; req_width = 3'd3; req_addr = 32'h0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst_resp_latency", 32'(n), 32'(LAT + 1));
      rst = 1'b1; resp_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; resp_ready = 1'b0;
      chk_reset_state("rst_resp");

      for (int i = 0; i < 200; i++) begin
         n = $urandom_range(0, 9);
         w = (n < 8) ? codes[n] : 3'd2;
         if ($urandom_range(0, 99) < 5) a = 32'h4000 + 32'($urandom_range(0, 255));
         else a = 32'($urandom_range(0, 255));
         xact(1'($urandom_range(0, 1)), w, a, $urandom, $urandom_range(0, 3) == 0 ? 2 : 0);
      end
      for (int i = 0; i < 64; i++) xact(1'b0, 3'd2, 32'(4 * i), 32'h0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
